// File: rtl/pwm_fan_ctrl_multi.sv
// Multi-channel PWM fan controller: shared prescaler/phase timebase, per-channel
// OFF/KICK/RUN sequencing with duty ramping, all updates taken on period boundaries.
module pwm_fan_ctrl_multi #(
  parameter int NumChannels  = 2,
  parameter int SettingWidth = 4,
  parameter int PrescaleDiv  = 16,
  parameter int RampPeriods  = 4,
  parameter int KickPeriods  = 8
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 en_i,
  input  logic [NumChannels*SettingWidth-1:0]  setting_i,
  output logic [NumChannels-1:0]               pwm_o,
  output logic                                 period_start_o,
  output logic [NumChannels-1:0]               ramp_active_o
);

  localparam int W     = SettingWidth;
  localparam int PresW = (PrescaleDiv > 1) ? $clog2(PrescaleDiv) : 1;
  localparam int RampW = (RampPeriods > 1) ? $clog2(RampPeriods) : 1;
  localparam int KickW = (KickPeriods > 1) ? $clog2(KickPeriods) : 1;

  localparam logic [PresW-1:0] PresLast  = PresW'(PrescaleDiv - 1);
  localparam logic [W-1:0]     PhaseLast = W'((1 << W) - 2);
  localparam logic [RampW-1:0] RampLast  = RampW'((RampPeriods > 0) ? RampPeriods - 1 : 0);
  localparam logic [KickW-1:0] KickInit  = KickW'((KickPeriods > 0) ? KickPeriods - 1 : 0);

  typedef enum logic [1:0] {StOff, StKick, StRun} state_e;

  logic [PresW-1:0] presc_q, presc_d;
  logic [W-1:0]     phase_q, phase_d;
  logic             bnd_q, bnd_d;
  logic             period_start_q, period_start_d;
  logic             tick;
  logic             boundary;

  always_comb begin
    tick           = (presc_q == PresLast);
    boundary       = en_i && tick && (phase_q == PhaseLast);
    presc_d        = tick ? '0 : presc_q + PresW'(1);
    phase_d        = phase_q;
    if (tick) begin
      phase_d = (phase_q == PhaseLast) ? '0 : phase_q + W'(1);
    end
    bnd_d          = boundary;
    // Delayed twice so the pulse lines up with the registered PWM showing phase 0.
    period_start_d = en_i && bnd_q;
    if (!en_i) begin
      presc_d = '0;
      phase_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q        <= '0;
      phase_q        <= '0;
      bnd_q          <= 1'b0;
      period_start_q <= 1'b0;
    end else begin
      presc_q        <= presc_d;
      phase_q        <= phase_d;
      bnd_q          <= bnd_d;
      period_start_q <= period_start_d;
    end
  end

  assign period_start_o = period_start_q;

  for (genvar gi = 0; gi < NumChannels; gi++) begin : g_ch
    logic [W-1:0]     set_c;
    state_e           state_q, state_d;
    logic [W-1:0]     duty_q, duty_d;
    logic [W-1:0]     target_q, target_d;
    logic [RampW-1:0] ramp_cnt_q, ramp_cnt_d;
    logic [KickW-1:0] kick_cnt_q, kick_cnt_d;
    logic             pwm_q, pwm_d;

    assign set_c = setting_i[gi*W +: W];

    always_comb begin
      state_d    = state_q;
      duty_d     = duty_q;
      target_d   = target_q;
      ramp_cnt_d = ramp_cnt_q;
      kick_cnt_d = kick_cnt_q;
      pwm_d      = en_i && ((state_q == StKick) || (phase_q < duty_q));
      if (!en_i) begin
        state_d    = StOff;
        duty_d     = '0;
        target_d   = '0;
        ramp_cnt_d = '0;
        kick_cnt_d = '0;
      end else if (boundary) begin
        target_d = set_c;
        case (state_q)
          StOff: begin
            if (set_c != '0) begin
              if (KickPeriods > 0) begin
                state_d    = StKick;
                kick_cnt_d = KickInit;
              end else begin
                state_d = StRun;
                duty_d  = (RampPeriods > 0) ? W'(1) : set_c;
              end
            end
          end
          StKick: begin
            if (kick_cnt_q == '0) begin
              if (set_c == '0) begin
                state_d = StOff;
              end else begin
                state_d = StRun;
                duty_d  = set_c;
              end
            end else begin
              kick_cnt_d = kick_cnt_q - KickW'(1);
            end
          end
          StRun: begin
            if (RampPeriods == 0) begin
              duty_d = set_c;
            end else if (duty_q == set_c) begin
              ramp_cnt_d = '0;
            end else if (ramp_cnt_q == RampLast) begin
              ramp_cnt_d = '0;
              duty_d     = (set_c > duty_q) ? duty_q + W'(1) : duty_q - W'(1);
            end else begin
              ramp_cnt_d = ramp_cnt_q + RampW'(1);
            end
            if ((duty_d == '0) && (set_c == '0)) begin
              state_d    = StOff;
              ramp_cnt_d = '0;
            end
          end
          default: state_d = StOff;
        endcase
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_q    <= StOff;
        duty_q     <= '0;
        target_q   <= '0;
        ramp_cnt_q <= '0;
        kick_cnt_q <= '0;
        pwm_q      <= 1'b0;
      end else begin
        state_q    <= state_d;
        duty_q     <= duty_d;
        target_q   <= target_d;
        ramp_cnt_q <= ramp_cnt_d;
        kick_cnt_q <= kick_cnt_d;
        pwm_q      <= pwm_d;
      end
    end

    assign pwm_o[gi]         = pwm_q;
    assign ramp_active_o[gi] = (state_q == StKick) ||
                               ((state_q == StRun) && (duty_q != target_q));
  end

endmodule

// File: tb/tb_pwm_fan_ctrl_multi.sv
// Bench for pwm_fan_ctrl_multi: four parameterisations against a time-based
// reference model, plus hand-checked scenario tables.
module tb_pwm_fan_ctrl_multi;
  localparam int N  = 2;
  localparam int W  = 4;
  localparam int ND = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic [N*W-1:0] setting = '0;

  always #5 clk = ~clk;

  logic [N-1:0] pwm_w [ND];
  logic         ps_w  [ND];
  logic [N-1:0] ra_w  [ND];

  pwm_fan_ctrl_multi #(.NumChannels(N), .SettingWidth(W), .PrescaleDiv(4), .RampPeriods(0), .KickPeriods(0))
    u_d0 (.clk_i(clk), .rst_ni(rst_n), .en_i(en), .setting_i(setting),
          .pwm_o(pwm_w[0]), .period_start_o(ps_w[0]), .ramp_active_o(ra_w[0]));
  pwm_fan_ctrl_multi #(.NumChannels(N), .SettingWidth(W), .PrescaleDiv(4), .RampPeriods(0), .KickPeriods(2))
    u_d1 (.clk_i(clk), .rst_ni(rst_n), .en_i(en), .setting_i(setting),
          .pwm_o(pwm_w[1]), .period_start_o(ps_w[1]), .ramp_active_o(ra_w[1]));
  pwm_fan_ctrl_multi #(.NumChannels(N), .SettingWidth(W), .PrescaleDiv(4), .RampPeriods(2), .KickPeriods(0))
    u_d2 (.clk_i(clk), .rst_ni(rst_n), .en_i(en), .setting_i(setting),
          .pwm_o(pwm_w[2]), .period_start_o(ps_w[2]), .ramp_active_o(ra_w[2]));
  pwm_fan_ctrl_multi #(.NumChannels(N), .SettingWidth(W), .PrescaleDiv(2), .RampPeriods(1), .KickPeriods(1))
    u_d3 (.clk_i(clk), .rst_ni(rst_n), .en_i(en), .setting_i(setting),
          .pwm_o(pwm_w[3]), .period_start_o(ps_w[3]), .ramp_active_o(ra_w[3]));

  int cfg_pd [ND] = '{4, 4, 4, 2};
  int cfg_rp [ND] = '{0, 0, 2, 1};
  int cfg_kp [ND] = '{0, 2, 0, 1};

  int checks = 0;
  int failures = 0;

  // Reference model: time since enable, per-channel state 0=off 1=kick 2=run.
  int m_t    [ND];
  int m_st   [ND][N];
  int m_duty [ND][N];
  int m_tgt  [ND][N];
  int m_rc   [ND][N];
  int m_kc   [ND][N];
  int m_pwm  [ND][N];
  int m_b1   [ND];
  int m_ps   [ND];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int d = 0; d < ND; d++) begin
      m_t[d] = 0; m_b1[d] = 0; m_ps[d] = 0;
      for (int c = 0; c < N; c++) begin
        m_st[d][c] = 0; m_duty[d][c] = 0; m_tgt[d][c] = 0;
        m_rc[d][c] = 0; m_kc[d][c] = 0; m_pwm[d][c] = 0;
      end
    end
  endtask

  task automatic model_apply(input int d, input int c, input int t);
    int rp;
    int kp;
    rp = cfg_rp[d];
    kp = cfg_kp[d];
    m_tgt[d][c] = t;
    if (m_st[d][c] == 0) begin
      if (t != 0) begin
        if (kp > 0) begin m_st[d][c] = 1; m_kc[d][c] = kp - 1; end
        else begin m_st[d][c] = 2; m_duty[d][c] = (rp > 0) ? 1 : t; end
      end
    end else if (m_st[d][c] == 1) begin
      if (m_kc[d][c] > 0) m_kc[d][c]--;
      else if (t == 0) m_st[d][c] = 0;
      else begin m_st[d][c] = 2; m_duty[d][c] = t; end
    end else begin
      if (rp == 0) m_duty[d][c] = t;
      else if (m_duty[d][c] == t) m_rc[d][c] = 0;
      else if (m_rc[d][c] + 1 < rp) m_rc[d][c]++;
      else begin
        m_rc[d][c] = 0;
        m_duty[d][c] = (t > m_duty[d][c]) ? m_duty[d][c] + 1 : m_duty[d][c] - 1;
      end
      if (m_duty[d][c] == 0 && t == 0) begin m_st[d][c] = 0; m_rc[d][c] = 0; end
    end
  endtask

  task automatic model_edge();
    int per;
    int ph;
    int bnd;
    if (!rst_n || !en) begin
      model_clear();
      return;
    end
    for (int d = 0; d < ND; d++) begin
      per = cfg_pd[d] * 15;
      ph  = (m_t[d] / cfg_pd[d]) % 15;
      bnd = ((m_t[d] % per) == per - 1) ? 1 : 0;
      for (int c = 0; c < N; c++)
        m_pwm[d][c] = (m_st[d][c] == 1 || ph < m_duty[d][c]) ? 1 : 0;
      m_ps[d] = m_b1[d];
      m_b1[d] = bnd;
      if (bnd != 0)
        for (int c = 0; c < N; c++) model_apply(d, c, int'(setting[c*W +: W]));
      m_t[d] = (m_t[d] + 1) % per;
    end
  endtask

  task automatic check_all();
    int e;
    int a;
    for (int d = 0; d < ND; d++) begin
      e = m_ps[d] << N;
      for (int c = 0; c < N; c++) begin
        e |= m_pwm[d][c] << c;
        if (m_st[d][c] == 1 || (m_st[d][c] == 2 && m_duty[d][c] != m_tgt[d][c]))
          e |= 1 << (N + 1 + c);
      end
      a = int'({ra_w[d], ps_w[d], pwm_w[d]});
      check($sformatf("dut%0d_ra_ps_pwm", d), a, e);
    end
  endtask

  task automatic step_cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic wait_ps(input int d, input int maxc, output int n, output int anyhi);
    n = 0;
    anyhi = 0;
    while (ps_w[d] !== 1'b1 && n < maxc) begin
      if (pwm_w[d] != '0) anyhi = 1;
      step_cycle();
      n++;
    end
    if (ps_w[d] !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL wait_ps_timeout dut=%0d waited=%0d limit=%0d", d, n, maxc);
    end
  endtask

  task automatic measure(input int d, input int n, input int chg_at, input logic [N*W-1:0] chg_set,
                         output int hi0, output int hi1, output int ra0, output int ra1, output int psn);
    hi0 = 0; hi1 = 0; ra0 = 0; ra1 = 0; psn = 0;
    for (int i = 0; i < n; i++) begin
      hi0 += int'(pwm_w[d][0]);
      hi1 += int'(pwm_w[d][1]);
      psn += int'(ps_w[d]);
      if (i == n / 2) begin ra0 = int'(ra_w[d][0]); ra1 = int'(ra_w[d][1]); end
      if (i == chg_at) setting = chg_set;
      step_cycle();
    end
  endtask

  typedef struct { logic [3:0] s0; logic [3:0] s1; int hi0; int hi1; } tvec_t;
  typedef struct { int hi; int ra; } rvec_t;
  tvec_t tbl [5];
  rvec_t rtbl [9];

  initial begin
    int n, anyhi, h0, h1, r0, r1, psn, prev0, prev1;
    tbl[0] = '{4'd0,  4'd15, 0,  60};
    tbl[1] = '{4'd15, 4'd0,  60, 0};
    tbl[2] = '{4'd7,  4'd9,  28, 36};
    tbl[3] = '{4'd1,  4'd14, 4,  56};
    tbl[4] = '{4'd0,  4'd0,  0,  0};
    rtbl[0] = '{4, 1};  rtbl[1] = '{4, 1};  rtbl[2] = '{8, 1};
    rtbl[3] = '{8, 1};  rtbl[4] = '{12, 0}; rtbl[5] = '{12, 1};
    rtbl[6] = '{8, 1};  rtbl[7] = '{8, 1};  rtbl[8] = '{4, 0};
    model_clear();

    // Reset state
    repeat (3) step_cycle();
    check("rst_pwm_d0", int'(pwm_w[0]), 0);
    check("rst_ps_d1", int'(ps_w[1]), 0);
    check("rst_ra_d1", int'(ra_w[1]), 0);

    // Fixed duty 5 held from reset release
    en = 1'b1;
    setting = {4'd0, 4'd5};
    rst_n = 1'b1;
    wait_ps(0, 200, n, anyhi);
    check("first_boundary_delay", n, 61);
    check("low_before_first_boundary", anyhi, 0);
    measure(0, 60, -1, setting, h0, h1, r0, r1, psn);
    check("duty5_high_cycles", h0, 20);
    check("ps_pulses_per_period", psn, 1);
    check("ps_after_60_cycles", int'(ps_w[0]), 1);
    $display("scenario fixed_duty: first_ps=%0d high=%0d", n, h0);

    // Setting changes mid-period must wait for the boundary
    prev0 = 20; prev1 = 0;
    for (int i = 0; i < 5; i++) begin
      measure(0, 60, 10, {tbl[i].s1, tbl[i].s0}, h0, h1, r0, r1, psn);
      check($sformatf("tbl%0d_hold_ch0", i), h0, prev0);
      check($sformatf("tbl%0d_hold_ch1", i), h1, prev1);
      measure(0, 60, -1, setting, h0, h1, r0, r1, psn);
      check($sformatf("tbl%0d_new_ch0", i), h0, tbl[i].hi0);
      check($sformatf("tbl%0d_new_ch1", i), h1, tbl[i].hi1);
      $display("vector %0d: set=%0d/%0d high=%0d/%0d", i, tbl[i].s0, tbl[i].s1, h0, h1);
      prev0 = tbl[i].hi0; prev1 = tbl[i].hi1;
    end

    // Kick-start on dut1 channel 1
    measure(1, 60, 10, {4'd9, 4'd0}, h0, h1, r0, r1, psn);
    measure(1, 60, -1, setting, h0, h1, r0, r1, psn);
    check("kick_p1_high", h1, 60);
    check("kick_p1_ramp_active", r1, 1);
    measure(1, 60, -1, setting, h0, h1, r0, r1, psn);
    check("kick_p2_high", h1, 60);
    check("kick_p2_ramp_active", r1, 1);
    measure(1, 60, -1, setting, h0, h1, r0, r1, psn);
    check("kick_run_high", h1, 36);
    check("kick_run_ramp_active", r1, 0);
    $display("scenario kick: run_high=%0d ramp_active=%0d", h1, r1);

    // Enable drop mid-period at duty 10
    measure(0, 60, 10, {4'd9, 4'd10}, h0, h1, r0, r1, psn);
    measure(0, 20, -1, setting, h0, h1, r0, r1, psn);
    check("duty10_pwm_before_disable", int'(pwm_w[0][0]), 1);
    en = 1'b0;
    step_cycle();
    check("disable_pwm_d0", int'(pwm_w[0]), 0);
    check("disable_pwm_d1", int'(pwm_w[1]), 0);
    check("disable_ra_d1", int'(ra_w[1]), 0);
    repeat (4) step_cycle();
    setting = {4'd0, 4'd3};
    en = 1'b1;
    wait_ps(0, 200, n, anyhi);
    check("reenable_boundary_delay", n, 61);
    check("reenable_low_before_boundary", anyhi, 0);
    $display("scenario enable: first_ps=%0d", n);

    // Ramp on dut2 channel 0: 0 -> 3, then redirected to 1
    for (int i = 0; i < 9; i++) begin
      measure(2, 60, (i == 4) ? 40 : -1, {4'd0, 4'd1}, h0, h1, r0, r1, psn);
      check($sformatf("ramp_w%0d_high", i), h0, rtbl[i].hi);
      check($sformatf("ramp_w%0d_active", i), r0, rtbl[i].ra);
      $display("ramp window %0d: high=%0d ramp_active=%0d", i, h0, r0);
    end

    // Asynchronous reset in the middle of a two-channel kick
    en = 1'b0;
    step_cycle();
    setting = {4'd9, 4'd9};
    en = 1'b1;
    wait_ps(1, 200, n, anyhi);
    measure(1, 20, -1, setting, h0, h1, r0, r1, psn);
    check("kick_both_pwm", int'(pwm_w[1]), 3);
    check("kick_both_ra", int'(ra_w[1]), 3);
    #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    check("async_rst_pwm_d1", int'(pwm_w[1]), 0);
    check("async_rst_ra_d1", int'(ra_w[1]), 0);
    check_all();
    repeat (3) step_cycle();
    setting = {4'd0, 4'd5};
    rst_n = 1'b1;
    wait_ps(0, 200, n, anyhi);
    check("post_rst_boundary_delay", n, 61);
    check("post_rst_low", anyhi, 0);
    measure(0, 60, -1, setting, h0, h1, r0, r1, psn);
    check("post_rst_duty5_high", h0, 20);
    $display("scenario async_reset: first_ps=%0d high=%0d", n, h0);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        for (int c = 0; c < N; c++)
          setting[c*W +: W] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      end
      if ($urandom_range(0, 599) == 0) en = 1'b0;
      else if (!en && $urandom_range(0, 3) == 0) en = 1'b1;
      step_cycle();
    end
    $display("random phase done: checks so far=%0d", checks);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
